// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of data_mem: one grant per cycle, registered responses, port lock with a starvation bound.
// Build option: define DMEM_ARB_RR_EN for round-robin IDLE tie-breaking; otherwise port 0 wins IDLE ties.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DEPTH    = 64,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p0_lock,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          last;
  logic          hold_full, own_is_1, own_req, oth_req, tie_to_p1;
  logic          win_valid, win1, win_lock, win_oth_req;
  logic          sel_we, in_range;

`ifdef DMEM_ARB_RR_EN
  // The port not granted most recently wins a tie.
  assign tie_to_p1 = ~last;
`else
  assign tie_to_p1 = 1'b0;
`endif

  assign hold_full = (hold_cnt == HW'(MAX_HOLD));
  assign own_is_1  = (state == OWN1);
  assign own_req   = own_is_1 ? p1_req : p0_req;
  assign oth_req   = own_is_1 ? p0_req : p1_req;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win1      = 1'b0;
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (state == IDLE) begin
      win_valid = p0_req | p1_req;
      win1      = p1_req & (~p0_req | tie_to_p1);
    end else begin
      win_valid = own_req | oth_req;
      // While owning, 'last' is the owner, so ~last names the starved port.
      if (oth_req && hold_full) win1 = ~last;
      else if (own_req)         win1 = own_is_1;
      else                      win1 = ~own_is_1;
    end
    win_valid   = win_valid & reset_n;
    win_lock    = win1 ? p1_lock : p0_lock;
    win_oth_req = win1 ? p0_req : p1_req;

    if (!win_valid) begin
      hold_nxt = '0;
    end else if (win_lock && (state == IDLE || win1 == own_is_1)) begin
      state_nxt = win1 ? OWN1 : OWN0;
      hold_nxt  = win_oth_req ? hold_cnt + HW'(1) : '0;
    end else begin
      state_nxt = IDLE;
      hold_nxt  = '0;
    end
  end

  assign p0_gnt   = win_valid & ~win1;
  assign p1_gnt   = win_valid & win1;
  assign mem_a    = p1_gnt ? p1_addr  : p0_addr;
  assign mem_wd   = p1_gnt ? p1_wdata : p0_wdata;
  assign sel_we   = p1_gnt ? p1_we    : p0_we;
  assign in_range = (mem_a[AW-1:2] < (AW-2)'(DEPTH));
  assign mem_we   = win_valid & sel_we & in_range;

  // NOTE: reset is sampled synchronously here; gnt/mem_we are gated on reset_n combinationally above.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last      <= 1'b1;
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
      p1_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      if (win_valid) last <= win1;
      p0_rvalid <= p0_gnt;
      p0_err    <= p0_gnt & ~in_range;
      p0_rdata  <= (p0_gnt && !sel_we && in_range) ? mem_rd : '0;
      p1_rvalid <= p1_gnt;
      p1_err    <= p1_gnt & ~in_range;
      p1_rdata  <= (p1_gnt && !sel_we && in_range) ? mem_rd : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all checked against a cycle-level model.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, DEPTH = 64, MAX_HOLD = 8;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid, p0_err;
  logic p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // data_mem stand-in: async read, write on posedge, preloaded on the first edge
  logic [31:0] env_mem [0:DEPTH-1];
  bit env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
      env_ready <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_a[7:2]] <= mem_wd;
    end
  end
  assign mem_rd = env_mem[mem_a[7:2]];

  // reference model: owner (-1 = none), streak of locked grants, most recent winner
  logic [31:0] ref_mem [0:DEPTH-1];
  int m_owner, m_streak, m_last;
  int checks = 0, errors = 0;
  logic [1:0] g_obs_gnt;
  logic g_memwe;

  task automatic set_p(input int p, input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] data);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_lock = lock; p0_addr = addr; p0_wdata = data;
    end else begin
      p1_req = req; p1_we = we; p1_lock = lock; p1_addr = addr; p1_wdata = data;
    end
  endtask

  task automatic set_idle();
    set_p(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_p(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One clock: predict the grant, check combinational outputs, clock, check responses.
  task automatic cycle();
    int win;
    logic [1:0] rq;
    logic w_we, w_lock, exp_we;
    logic [31:0] w_addr, w_data, exp_rd;
    logic [29:0] wword;
    bit inr, exp_err;
    #1;
    rq  = {p1_req, p0_req};
    win = -1;
    if (reset_n) begin
      if (m_owner < 0) begin
        if (rq == 2'b11) win = (RR && m_last == 0) ? 1 : 0;
        else if (rq[0])  win = 0;
        else if (rq[1])  win = 1;
      end else if (rq[1-m_owner] && m_streak == MAX_HOLD) win = 1 - m_owner;
      else if (rq[m_owner])   win = m_owner;
      else if (rq[1-m_owner]) win = 1 - m_owner;
    end
    w_we   = (win == 1) ? p1_we    : p0_we;
    w_lock = (win == 1) ? p1_lock  : p0_lock;
    w_addr = (win == 1) ? p1_addr  : p0_addr;
    w_data = (win == 1) ? p1_wdata : p0_wdata;
    wword  = w_addr[31:2];
    inr    = (wword < 30'(DEPTH));
    exp_we = (win >= 0) && w_we && inr;

    g_obs_gnt = {p1_gnt, p0_gnt};
    g_memwe   = mem_we;
    checks += 3;
    if (p0_gnt !== (win == 0)) begin errors++; $display("FAIL p0_gnt t=%0t got %b want %b", $time, p0_gnt, win == 0); end
    if (p1_gnt !== (win == 1)) begin errors++; $display("FAIL p1_gnt t=%0t got %b want %b", $time, p1_gnt, win == 1); end
    if (mem_we !== exp_we) begin errors++; $display("FAIL mem_we t=%0t got %b want %b", $time, mem_we, exp_we); end
    if (win >= 0) begin
      checks++;
      if (mem_a !== w_addr) begin errors++; $display("FAIL mem_a t=%0t got %h want %h", $time, mem_a, w_addr); end
      if (w_we) begin
        checks++;
        if (mem_wd !== w_data) begin errors++; $display("FAIL mem_wd t=%0t got %h want %h", $time, mem_wd, w_data); end
      end
    end

    exp_rd  = (win >= 0 && !w_we && inr) ? ref_mem[wword[5:0]] : 32'h0;
    exp_err = (win >= 0) && !inr;
    if (exp_we) ref_mem[wword[5:0]] = w_data;

    if (!reset_n) begin
      m_owner = -1; m_streak = 0; m_last = 1;
    end else if (win < 0) begin
      m_streak = 0;
    end else begin
      m_last = win;
      if (w_lock && (m_owner < 0 || m_owner == win)) begin
        m_owner  = win;
        m_streak = rq[1-win] ? m_streak + 1 : 0;
      end else begin
        m_owner = -1; m_streak = 0;
      end
    end

    @(posedge clk);
    #1;
    checks += 6;
    if (p0_rvalid !== (win == 0)) begin errors++; $display("FAIL p0_rvalid t=%0t got %b want %b", $time, p0_rvalid, win == 0); end
    if (p0_rdata !== ((win == 0) ? exp_rd : 32'h0)) begin errors++; $display("FAIL p0_rdata t=%0t got %h want %h", $time, p0_rdata, (win == 0) ? exp_rd : 32'h0); end
    if (p0_err !== ((win == 0) && exp_err)) begin errors++; $display("FAIL p0_err t=%0t got %b want %b", $time, p0_err, (win == 0) && exp_err); end
    if (p1_rvalid !== (win == 1)) begin errors++; $display("FAIL p1_rvalid t=%0t got %b want %b", $time, p1_rvalid, win == 1); end
    if (p1_rdata !== ((win == 1) ? exp_rd : 32'h0)) begin errors++; $display("FAIL p1_rdata t=%0t got %h want %h", $time, p1_rdata, (win == 1) ? exp_rd : 32'h0); end
    if (p1_err !== ((win == 1) && exp_err)) begin errors++; $display("FAIL p1_err t=%0t got %b want %b", $time, p1_err, (win == 1) && exp_err); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_p(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_p(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    repeat (2) begin
      cycle();
      checks++;
      if (g_obs_gnt !== 2'b00 || g_memwe !== 1'b0) begin errors++; $display("FAIL reset_quiet gnt=%b mem_we=%b want 00/0", g_obs_gnt, g_memwe); end
    end
    reset_n = 1'b1;
    cycle();
    checks++;
    if (g_obs_gnt !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", g_obs_gnt); end
    p0_req = 1'b0;
    cycle();
    set_idle();
    cycle();
  endtask

  task automatic test_single_p0();
    set_p(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    cycle();
    checks++;
    if (g_obs_gnt !== 2'b01 || g_memwe !== 1'b1) begin errors++; $display("FAIL single_write gnt=%b mem_we=%b want 01/1", g_obs_gnt, g_memwe); end
    set_p(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    cycle();
    checks++;
    if (g_obs_gnt !== 2'b01 || p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF || p0_err !== 1'b0) begin
      errors++; $display("FAIL single_read gnt=%b rvalid=%b rdata=%h err=%b want 01/1/deadbeef/0", g_obs_gnt, p0_rvalid, p0_rdata, p0_err);
    end
    set_idle();
    cycle();
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    set_p(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    set_p(1, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      // port 0 was granted last, so round-robin opens with port 1
      exp = RR ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b01;
      checks++;
      if (g_obs_gnt !== exp) begin errors++; $display("FAIL tie_%0d got %b want %b", i, g_obs_gnt, exp); end
    end
    set_idle();
    cycle();
  endtask

  task automatic test_lock_starve();
    logic [1:0] exp;
    set_p(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    cycle();
    set_p(0, 1'b1, 1'b0, 1'b1, 32'h34, 32'h0);
    set_p(1, 1'b1, 1'b0, 1'b0, 32'h38, 32'h0);
    for (int i = 0; i <= MAX_HOLD; i++) begin
      cycle();
      exp = (i < MAX_HOLD) ? 2'b01 : 2'b10;
      checks++;
      if (g_obs_gnt !== exp) begin errors++; $display("FAIL lock_%0d got %b want %b", i, g_obs_gnt, exp); end
    end
    p1_req  = 1'b0;
    p0_lock = 1'b0;
    cycle();
    set_idle();
    cycle();
  endtask

  task automatic test_out_of_range();
    set_p(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h1234_5678);
    cycle();
    checks++;
    if (g_obs_gnt !== 2'b10 || g_memwe !== 1'b0 || p1_rvalid !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 32'h0) begin
      errors++; $display("FAIL oor_write gnt=%b mem_we=%b rvalid=%b err=%b rdata=%h want 10/0/1/1/0", g_obs_gnt, g_memwe, p1_rvalid, p1_err, p1_rdata);
    end
    set_p(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    checks++;
    if (p1_rdata !== init_word(0) || p1_err !== 1'b0) begin errors++; $display("FAIL oor_word0 rdata=%h err=%b want %h/0", p1_rdata, p1_err, init_word(0)); end
    set_idle();
    cycle();
  endtask

  task automatic test_reset_mid_lock();
    set_p(1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    cycle();
    reset_n = 1'b0;
    cycle();
    checks++;
    if (g_obs_gnt !== 2'b00 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL midlock_reset gnt=%b rvalid=%b want 00/0", g_obs_gnt, p1_rvalid); end
    reset_n = 1'b1;
    set_p(0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    set_p(1, 1'b1, 1'b0, 1'b0, 32'h48, 32'h0);
    cycle();
    checks++;
    if (g_obs_gnt !== 2'b01) begin errors++; $display("FAIL midlock_tie got %b want 01", g_obs_gnt); end
    set_idle();
    cycle();
  endtask

  task automatic test_random();
    bit pend0 = 1'b0, pend1 = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!pend0 && $urandom_range(3) != 0) begin
        pend0 = 1'b1;
        set_p(0, 1'b1, 1'($urandom_range(1)), ($urandom_range(2) == 0), 32'($urandom_range(71)) << 2, $urandom());
      end
      if (!pend1 && $urandom_range(3) != 0) begin
        pend1 = 1'b1;
        set_p(1, 1'b1, 1'($urandom_range(1)), ($urandom_range(2) == 0), 32'($urandom_range(71)) << 2, $urandom());
      end
      reset_n = ($urandom_range(99) != 0);
      cycle();
      if (g_obs_gnt[0]) begin pend0 = 1'b0; p0_req = 1'b0; end
      if (g_obs_gnt[1]) begin pend1 = 1'b0; p1_req = 1'b0; end
    end
    reset_n = 1'b1;
    set_idle();
    cycle();
  endtask

  initial begin
    reset_n  = 1'b0;
    set_idle();
    m_owner  = -1;
    m_streak = 0;
    m_last   = 1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_single_p0();
    test_tie();
    test_lock_starve();
    test_out_of_range();
    test_reset_mid_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
